// File: rtl/md_hazard_ctrl.sv
// rtl/md_hazard_ctrl.sv - mult/div issue, hazard detection and write-port arbitration
// Optional STALL_PERF_EN adds a saturating stall_cycles counter.
module md_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_uses_rt,
  input  logic             fd_is_md,
  input  logic [4:0]       fd_rd,
  input  logic             dx_is_load,
  input  logic [4:0]       dx_rd,
  input  logic             mw_reg_we,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             md_go,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_count,
  output logic             md_wb,
  output logic [4:0]       md_wb_rd
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_q, rd_d;
  logic             load_use, md_dep, md_struct, wb_hold;
  logic             stall_int, go_int, wb_int;

  function automatic logic match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  // Outputs are additionally gated by reset_n so everything reads 0 while reset is held.
  always_comb begin
    load_use  = dx_is_load && (match(dx_rd, fd_rs) || (fd_uses_rt && match(dx_rd, fd_rt)));
    md_dep    = (state_q != IDLE) && (match(rd_q, fd_rs) || (fd_uses_rt && match(rd_q, fd_rt)));
    md_struct = fd_is_md && (state_q != IDLE);
    wb_hold   = (state_q == WB) && mw_reg_we;
    stall_int = reset_n && !flush && (load_use || md_dep || md_struct || wb_hold);
    go_int    = reset_n && fd_is_md && !stall_int && !flush && (state_q == IDLE);
    wb_int    = reset_n && (state_q == WB) && !mw_reg_we;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (go_int) begin
          state_d = RUN;
          count_d = LAST_COUNT;
          rd_d    = fd_rd;
        end
      end
      RUN: begin
        if (count_q == '0) begin
          state_d = WB;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      WB: begin
        if (wb_int) begin
          state_d = IDLE;
          rd_d    = 5'd0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        rd_d    = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
    end
  end

  assign stall    = stall_int;
  assign bubble   = stall_int;
  assign md_go    = go_int;
  assign md_busy  = (state_q != IDLE);
  assign md_count = count_q;
  assign md_wb    = wb_int;
  assign md_wb_rd = (state_q == WB) ? rd_q : 5'd0;

`ifdef STALL_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
    end else if (stall_int && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb/tb_md_hazard_ctrl.sv - randomized and directed checks of md_hazard_ctrl against a timeline model
module tb_md_hazard_ctrl;

  localparam int L = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] fd_rs, fd_rt, fd_rd, dx_rd;
  logic       fd_uses_rt, fd_is_md, dx_is_load, mw_reg_we, flush;
  logic       stall, bubble, md_go, md_busy, md_wb;
  logic [5:0] md_count;
  logic [4:0] md_wb_rd;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  md_hazard_ctrl #(.MD_LATENCY(L), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt), .fd_is_md(fd_is_md), .fd_rd(fd_rd),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .mw_reg_we(mw_reg_we), .flush(flush),
    .stall(stall), .bubble(bubble), .md_go(md_go), .md_busy(md_busy), .md_count(md_count),
    .md_wb(md_wb), .md_wb_rd(md_wb_rd)
`ifdef STALL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Timeline model: an op issued in cycle go_cyc is in flight for L cycles, then waits for the port.
  bit          pend = 0;
  int          go_cyc = 0;
  int          cyc = 0;
  logic [4:0]  pend_rd = 0;
  logic [31:0] stall_cnt = 0;
  logic        e_stall, e_go, e_busy, e_wb;
  logic [5:0]  e_count;
  logic [4:0]  e_wb_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic m(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 0);
  endfunction

  task automatic compute_exp();
    int  rel;
    bit  in_run, in_wb, hz;
    rel    = cyc - go_cyc;
    in_run = pend && (rel <= L);
    in_wb  = pend && (rel > L);
    hz = (dx_is_load && (m(dx_rd, fd_rs) || (fd_uses_rt && m(dx_rd, fd_rt))))
      || (pend && (m(pend_rd, fd_rs) || (fd_uses_rt && m(pend_rd, fd_rt))))
      || (fd_is_md && pend)
      || (in_wb && mw_reg_we);
    e_stall = reset_n && !flush && hz;
    e_go    = reset_n && fd_is_md && !e_stall && !flush;
    e_busy  = reset_n && pend;
    e_wb    = reset_n && in_wb && !mw_reg_we;
    e_wb_rd = (reset_n && in_wb) ? pend_rd : 5'd0;
    e_count = (reset_n && in_run) ? 6'(L - rel) : 6'd0;
  endtask

  task automatic check_model();
    #1;
    compute_exp();
    chk("stall", 32'(stall), 32'(e_stall));
    chk("bubble", 32'(bubble), 32'(e_stall));
    chk("md_go", 32'(md_go), 32'(e_go));
    chk("md_busy", 32'(md_busy), 32'(e_busy));
    chk("md_count", 32'(md_count), 32'(e_count));
    chk("md_wb", 32'(md_wb), 32'(e_wb));
    chk("md_wb_rd", 32'(md_wb_rd), 32'(e_wb_rd));
`ifdef STALL_PERF_EN
    chk("stall_cycles", stall_cycles, stall_cnt);
`endif
  endtask

  task automatic advance();
    @(posedge clock);
    if (!reset_n) begin
      pend = 0;
      stall_cnt = 0;
    end else begin
      if (e_go) begin
        pend = 1;
        go_cyc = cyc;
        pend_rd = fd_rd;
      end else if (e_wb) begin
        pend = 0;
      end
      if (e_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt++;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_in();
    fd_rs = 0; fd_rt = 0; fd_rd = 0; dx_rd = 0;
    fd_uses_rt = 0; fd_is_md = 0; dx_is_load = 0; mw_reg_we = 0; flush = 0;
  endtask

  initial begin
    idle_in();
    reset_n = 0;
    @(negedge clock);
    check_model();
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_count", 32'(md_count), 0);
    chk("rst_wb", 32'(md_wb), 0);
    advance();
    reset_n = 1;

    // load-use, and r0 never hazards
    dx_is_load = 1; dx_rd = 5; fd_rs = 5;
    check_model();
    chk("lu_stall", 32'(stall), 1);
    chk("lu_bubble", 32'(bubble), 1);
    advance();
    dx_rd = 0; fd_rs = 0;
    check_model();
    chk("lu_r0_stall", 32'(stall), 0);
    advance();

    // issue, dependency, structural, port arbitration
    idle_in(); fd_is_md = 1; fd_rd = 9;
    check_model();
    chk("issue_go", 32'(md_go), 1);
    advance();
    idle_in(); fd_rt = 9; fd_uses_rt = 1;
    check_model();
    chk("dep_stall", 32'(stall), 1);
    chk("cnt3", 32'(md_count), 3);
    advance();
    fd_uses_rt = 0;
    check_model();
    chk("nodep_stall", 32'(stall), 0);
    chk("cnt2", 32'(md_count), 2);
    advance();
    idle_in(); fd_is_md = 1; fd_rd = 4;
    check_model();
    chk("struct_stall", 32'(stall), 1);
    chk("struct_go", 32'(md_go), 0);
    chk("cnt1", 32'(md_count), 1);
    advance();
    idle_in();
    check_model();
    chk("cnt0", 32'(md_count), 0);
    chk("run_busy", 32'(md_busy), 1);
    advance();
    for (int i = 0; i < 2; i++) begin
      mw_reg_we = 1;
      check_model();
      chk("hold_wb", 32'(md_wb), 0);
      chk("hold_stall", 32'(stall), 1);
      advance();
    end
    mw_reg_we = 0;
    check_model();
    chk("wb_pulse", 32'(md_wb), 1);
    chk("wb_rd", 32'(md_wb_rd), 9);
    advance();
    check_model();
    chk("after_wb_busy", 32'(md_busy), 0);

    // flush kills issue
    fd_is_md = 1; fd_rd = 3; flush = 1;
    check_model();
    chk("flush_go", 32'(md_go), 0);
    advance();
    idle_in();
    check_model();
    chk("flush_idle", 32'(md_busy), 0);
    advance();

    // reset mid-RUN at md_count==2
    fd_is_md = 1; fd_rd = 7;
    check_model();
    advance();
    idle_in();
    check_model();
    advance();
    check_model();
    chk("pre_rst_cnt", 32'(md_count), 2);
    reset_n = 0;
    #1;
    chk("rst_run_busy", 32'(md_busy), 0);
    chk("rst_run_cnt", 32'(md_count), 0);
    pend = 0; stall_cnt = 0;
    advance();
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      check_model();
      chk("no_wb_after_rst", 32'(md_wb), 0);
      advance();
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      fd_rs      = 5'($urandom_range(0, 3));
      fd_rt      = 5'($urandom_range(0, 3));
      fd_rd      = 5'($urandom_range(0, 3));
      dx_rd      = 5'($urandom_range(0, 3));
      fd_uses_rt = ($urandom_range(0, 1) == 1);
      fd_is_md   = ($urandom_range(0, 9) < 3);
      dx_is_load = ($urandom_range(0, 9) < 3);
      mw_reg_we  = ($urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 9) == 0);
      reset_n    = ($urandom_range(0, 199) != 0);
      check_model();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
